// File: rtl/tpu_c_reader.sv
// Drains C buffer rows 0..rows-1 and serializes each 128-bit row into 32-bit words on a valid/ready stream.
// Latency: first word valid two cycles after start is accepted; 6 cycles/row at full ready, plus 1 cycle FIN.
// Backpressure: out_valid/out_data/out_last hold while !out_ready; optional TPU_C_READER_PACK8_EN packs 4 saturated int8 lanes per row.
module tpu_c_reader #(
    parameter int ADDR_BITS  = 16,
    parameter int DATAC_BITS = 128,
    parameter int DATA_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rows,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_BITS-1:0]  C_rd_index,
    input  logic [DATAC_BITS-1:0] C_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_BITS-1:0]  out_data,
    output logic                  out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_FIN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_rows;
    logic [7:0]             r_row_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [DATA_BITS-1:0]   r_out_data;
    logic [ADDR_BITS-1:0]   r_rd_index;
    logic                   w_hs;
    logic                   w_final_row;
    logic                   w_last_word;

    assign w_hs        = r_out_valid && out_ready;
    assign w_final_row = (r_row_cnt == (r_rows - 8'd1));

`ifdef TPU_C_READER_PACK8_EN
    // Clamp a signed 32-bit lane into the int8 range.
    function automatic logic [7:0] sat8(input logic [31:0] v);
        if ($signed(v) > 32'sd127)
            return 8'h7F;
        else if ($signed(v) < -32'sd128)
            return 8'h80;
        else
            return v[7:0];
    endfunction

    // Lane 0 (most significant) lands in the top byte of the output word.
    function automatic logic [DATA_BITS-1:0] pack_row(input logic [DATAC_BITS-1:0] row);
        return {sat8(row[DATAC_BITS-1  -: 32]), sat8(row[DATAC_BITS-33 -: 32]),
                sat8(row[DATAC_BITS-65 -: 32]), sat8(row[DATAC_BITS-97 -: 32])};
    endfunction

    // Every row is a single word, so each handshake closes the row.
    assign w_last_word = 1'b1;
`else
    logic [DATAC_BITS-1:0]  r_row;
    logic [1:0]             r_word_cnt;
    logic [1:0]             w_word_inc;

    assign w_word_inc  = r_word_cnt + 2'd1;
    assign w_last_word = (r_word_cnt == 2'd3);

    // Word 0 is the most significant 32 bits of the row.
    function automatic logic [DATA_BITS-1:0] lane(input logic [DATAC_BITS-1:0] row, input logic [1:0] idx);
        return row[DATAC_BITS-1 - DATA_BITS*int'(idx) -: DATA_BITS];
    endfunction
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic: one RAM read per row, then stream its words until the last handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = (rows == 8'd0) ? S_FIN : S_REQ;
            S_REQ:  w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_SEND;
            S_SEND: if (w_hs && w_last_word) w_state_nxt = w_final_row ? S_FIN : S_REQ;
            S_FIN:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs and datapath; status flags are derived from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_rd_index  <= '0;
            r_rows      <= 8'd0;
            r_row_cnt   <= 8'd0;
`ifndef TPU_C_READER_PACK8_EN
            r_row       <= '0;
            r_word_cnt  <= 2'd0;
`endif
        end else begin
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_FIN);
            r_out_valid <= (w_state_nxt == S_SEND);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rows <= rows;
                        if (rows != 8'd0) begin
                            r_rd_index <= '0;
                            r_row_cnt  <= 8'd0;
                        end
                    end
                end
                S_WAIT: begin
`ifdef TPU_C_READER_PACK8_EN
                    r_out_data <= pack_row(C_data_out);
                    r_out_last <= w_final_row;
`else
                    r_row      <= C_data_out;
                    r_word_cnt <= 2'd0;
                    r_out_data <= C_data_out[DATAC_BITS-1 -: DATA_BITS];
                    r_out_last <= 1'b0;
`endif
                end
                S_SEND: begin
                    if (w_hs) begin
`ifndef TPU_C_READER_PACK8_EN
                        r_word_cnt <= w_word_inc;
`endif
                        if (w_last_word) begin
                            r_out_last <= 1'b0;
                            if (!w_final_row) begin
                                r_row_cnt  <= r_row_cnt + 8'd1;
                                r_rd_index <= ADDR_BITS'(r_row_cnt + 8'd1);
                            end
                        end else begin
`ifndef TPU_C_READER_PACK8_EN
                            r_out_data <= lane(r_row, w_word_inc);
                            r_out_last <= w_final_row && (w_word_inc == 2'd3);
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign out_data   = r_out_data;
    assign C_rd_index = r_rd_index;

endmodule

// File: tb/tb_tpu_c_reader.sv
// Self-checking bench for tpu_c_reader: scoreboard of expected words against observed handshakes.
// Latency: drives start/out_ready after each rising edge, samples on the falling edge.
// Backpressure: exercises steady, toggling and stalled out_ready.
module tb_tpu_c_reader;

`ifdef TPU_C_READER_PACK8_EN
    localparam int PER_ROW = 3;
`else
    localparam int PER_ROW = 6;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    rows;
    logic          busy;
    logic          done;
    logic [15:0]   C_rd_index;
    logic [127:0]  C_data_out;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;

    logic [127:0]  cmem [0:3];

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [32:0]   exp_q[$];
    logic [32:0]   obs_q[$];
    int            cyc = 0;
    int            start_cyc, done_cnt, done_k, last_busy_k, first_valid_k, stall_err, valid_cnt;
    logic          idx_nz, p_stall, p_last;
    logic [31:0]   p_data;

    tpu_c_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rows       (rows),
        .busy       (busy),
        .done       (done),
        .C_rd_index (C_rd_index),
        .C_data_out (C_data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // C buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (C_rd_index < 16'd4)
            C_data_out <= cmem[C_rd_index[1:0]];
        else
            C_data_out <= '0;
    end

`ifdef TPU_C_READER_PACK8_EN
    function automatic logic [7:0] sat8(input logic [31:0] v);
        int s;
        s = $signed(v);
        if (s > 127) return 8'h7F;
        if (s < -128) return 8'h80;
        return v[7:0];
    endfunction
`endif

    // One clock: drive ready, record what the DUT shows mid-cycle, advance past the next edge.
    task automatic tick(input logic rdy);
        out_ready = rdy;
        @(negedge clk);
        if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
        if (out_valid) valid_cnt++;
        if (out_valid && first_valid_k < 0) first_valid_k = cyc - start_cyc;
        if (done) begin done_cnt++; done_k = cyc - start_cyc; end
        if (busy) last_busy_k = cyc - start_cyc;
        if (C_rd_index != 16'd0) idx_nz = 1'b1;
        if (p_stall && (!out_valid || out_data !== p_data || out_last !== p_last)) stall_err++;
        p_stall = out_valid && !out_ready;
        p_data  = out_data;
        p_last  = out_last;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_rec();
        exp_q.delete();
        obs_q.delete();
        done_cnt = 0; done_k = -1; last_busy_k = -1; first_valid_k = -1;
        stall_err = 0; valid_cnt = 0; idx_nz = 1'b0; p_stall = 1'b0;
        start_cyc = cyc + 1;
    endtask

    // Reference model: the words a drain of r rows must produce, in order.
    task automatic push_exp(input int r);
        logic [127:0] rv;
        for (int row = 0; row < r; row++) begin
            rv = cmem[row];
`ifdef TPU_C_READER_PACK8_EN
            exp_q.push_back({row == r - 1, sat8(rv[127:96]), sat8(rv[95:64]), sat8(rv[63:32]), sat8(rv[31:0])});
`else
            for (int w = 0; w < 4; w++)
                exp_q.push_back({(row == r - 1) && (w == 3), rv[127 - 32*w -: 32]});
`endif
        end
    endtask

    task automatic start_drain(input int r, input logic rdy);
        clear_rec();
        push_exp(r);
        start = 1'b1;
        rows  = r[7:0];
        tick(rdy);
        start = 1'b0;
    endtask

    // Mode 0: ready high; mode 1: ready toggles every cycle.
    task automatic run(input int mode, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick(mode == 0 ? 1'b1 : logic'(k[0]));
            if (done_cnt > 0 && !busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; rows = 8'd0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", done); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", out_valid); end
        n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b required 0", out_last); end
        n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %h required 0", out_data); end
        n_tests++; if (C_rd_index !== 16'd0) begin n_fail++; $display("FAIL rst_index: got %h required 0", C_rd_index); end
        rst_n = 1'b1;
        tick(1'b0);
    endtask

    task automatic test_rows_zero();
        bit ok;
        start_drain(0, 1'b1);
        run(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL zero_timeout: got no done, required done"); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d required 1", done_cnt); end
        n_tests++; if (done_k !== 0) begin n_fail++; $display("FAIL zero_done_cycle: got %0d required 0", done_k); end
        n_tests++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL zero_valid: got %0d valid cycles required 0", valid_cnt); end
        n_tests++; if (idx_nz !== 1'b0) begin n_fail++; $display("FAIL zero_index: got nonzero index required 0"); end
    endtask

    task automatic test_basic();
        bit ok;
        logic [32:0] e, o;
        start_drain(2, 1'b1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy); end
        run(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done, required done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL basic_word: got none required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL basic_word: got %h required %h", o, e); end end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL basic_extra: got %0d extra words required 0", obs_q.size()); end
        n_tests++; if (first_valid_k !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d required 2", first_valid_k); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d required 1", done_cnt); end
        n_tests++; if (done_k !== 2*PER_ROW) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required %0d", done_k, 2*PER_ROW); end
        n_tests++; if (last_busy_k + 1 !== 2*PER_ROW + 1) begin n_fail++; $display("FAIL basic_drain_cycles: got %0d required %0d", last_busy_k + 1, 2*PER_ROW + 1); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [32:0] e, o;
        start_drain(2, 1'b0);
        run(1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no done, required done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL bp_word: got none required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL bp_word: got %h required %h", o, e); end end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bp_extra: got %0d extra words required 0", obs_q.size()); end
        n_tests++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls required 0", stall_err); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_cnt: got %0d required 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [32:0] e, o;
        start_drain(2, 1'b1);
        for (int k = 0; k < 50 && obs_q.size() < 1; k++) tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        e = exp_q[1];
        n_tests++; if (!(out_valid === 1'b1 && out_data === e[31:0])) begin n_fail++; $display("FAIL mid_pending: got v=%b %h required v=1 %h", out_valid, out_data, e[31:0]); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b required 0", out_valid); end
        n_tests++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL mid_rst_data: got %h required 0", out_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b0);
        start_drain(1, 1'b1);
        n_tests++; if (C_rd_index !== 16'd0) begin n_fail++; $display("FAIL mid_index: got %h required 0", C_rd_index); end
        run(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mid_timeout: got no done, required done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL mid_word: got none required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL mid_word: got %h required %h", o, e); end end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_extra: got %0d extra words required 0", obs_q.size()); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        logic [32:0] e, o;
        start_drain(2, 1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        start = 1'b1;
        rows  = 8'd1;
        tick(1'b1);
        start = 1'b0;
        run(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ign_timeout: got no done, required done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL ign_word: got none required %h", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL ign_word: got %h required %h", o, e); end end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ign_extra: got %0d extra words required 0", obs_q.size()); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ign_done_cnt: got %0d required 1", done_cnt); end
    endtask

`ifdef TPU_C_READER_PACK8_EN
    task automatic test_pack8();
        bit ok;
        logic [32:0] o;
        cmem[0] = 128'h00000005_FFFFFF00_00000200_FFFFFFFE;
        start_drain(1, 1'b1);
        run(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL pack_timeout: got no done, required done"); end
        n_tests++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL pack_count: got %0d words required 1", obs_q.size()); end
        else begin o = obs_q.pop_front(); if (o !== 33'h1_05807FFE) begin n_fail++; $display("FAIL pack_word: got %h required 105807ffe", o); end end
    endtask
`endif

    initial begin
        cmem[0] = 128'h00000001_00000002_00000003_00000004;
        cmem[1] = 128'h0000000A_0000000B_0000000C_0000000D;
        cmem[2] = 128'h0;
        cmem[3] = 128'h0;
        test_reset();
        test_rows_zero();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
`ifdef TPU_C_READER_PACK8_EN
        test_pack8();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
